// File: rtl/seg_pkg.sv
// seg_pkg: shared definitions for the segment display blocks.
//   hex2seg     - hex nibble to active-low {G,F,E,D,C,B,A} pattern
//   SEG_BLANK   - all segments dark
//   clog2_min1  - ceil(log2(n)) with a floor of 1, for counter/index widths
//   glyph_t     - segment pattern plus decimal point, as driven to the pins
package seg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef struct packed {
    logic [6:0] seg;
    logic       dp;
  } glyph_t;

  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

  function automatic logic [6:0] hex2seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: 2-flop synchroniser, stability counter and rising-edge pulse
// for a raw push button.
//   clk, reset_n - clock, synchronous active-low reset
//   btn_i        - asynchronous raw button level (1 = pressed)
//   rise_o       - one-cycle pulse on the cycle the debounced level goes 0->1
module btn_debounce
  import seg_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 65536
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_i,
  output logic rise_o
);

  localparam int CW = clog2_min1(DEBOUNCE_CYCLES);

  logic          sync1_q, sync2_q;
  logic          level_q;
  logic [CW-1:0] cnt_q;
  logic          accept;

  // The synchronised level has disagreed with the accepted level for
  // DEBOUNCE_CYCLES consecutive samples.
  assign accept = (sync2_q != level_q) && (cnt_q == CW'(DEBOUNCE_CYCLES - 1));
  assign rise_o = accept && sync2_q;

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of its neighbours (the synchroniser chain
  // depends on this to stay two flops deep).
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      if (sync2_q == level_q) begin
        cnt_q <= '0;
      end else if (accept) begin
        level_q <= sync2_q;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: multiplexed common-anode 7-segment driver with page select,
// per-digit blanking and decimal point, 16-level brightness and guard cycles.
//   clk, reset_n  - clock, synchronous active-low reset
//   page_data     - NUM_PAGES x NUM_DIGITS hex nibbles, digit 0 rightmost
//   page_dp       - decimal point request per page/digit (1 = lit)
//   blank         - per-digit force dark
//   brightness    - duty level 0..15
//   btn_next      - raw "next page" button
//   an, seg, dp   - active-low pin drives
//   page_sel      - currently selected page
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS      = 4,
  parameter int NUM_PAGES       = 4,
  parameter int SCAN_DIV        = 256,
  parameter int GUARD_CYCLES    = 4,
  parameter int DEBOUNCE_CYCLES = 65536
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic [NUM_PAGES*NUM_DIGITS*4-1:0] page_data,
  input  logic [NUM_PAGES*NUM_DIGITS-1:0]   page_dp,
  input  logic [NUM_DIGITS-1:0]             blank,
  input  logic [3:0]                        brightness,
  input  logic                              btn_next,
  output logic [NUM_DIGITS-1:0]             an,
  output logic [6:0]                        seg,
  output logic                              dp,
  output logic [clog2_min1(NUM_PAGES)-1:0]  page_sel
);

  localparam int SW = $clog2(SCAN_DIV);
  localparam int DW = clog2_min1(NUM_DIGITS);
  localparam int PW = clog2_min1(NUM_PAGES);

  logic [SW-1:0]         cnt_q, cnt_d;
  logic [DW-1:0]         idx_q, idx_d;    // digit loaded at the next slot boundary
  logic [DW-1:0]         disp_q, disp_d;  // digit whose glyph is on the pins
  logic                  live_q, live_d;  // a real glyph has been loaded since reset
  logic [PW-1:0]         page_q, page_d;
  glyph_t                glyph_q, glyph_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic                  slot_end;
  logic                  btn_rise;
  logic [3:0]            nibble;
  logic                  dp_req;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn (
    .clk    (clk),
    .reset_n(reset_n),
    .btn_i  (btn_next),
    .rise_o (btn_rise)
  );

  // NOTE: every signal written here gets a default first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    slot_end = (cnt_q == SW'(SCAN_DIV - 1));
    cnt_d    = cnt_q + 1'b1;
    idx_d    = idx_q;
    disp_d   = disp_q;
    live_d   = live_q;
    if (slot_end) begin
      disp_d = idx_q;
      live_d = 1'b1;
      idx_d  = (idx_q == DW'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end

    // Constant-index select keeps the mux free of out-of-range page/digit codes.
    nibble = '0;
    dp_req = 1'b0;
    for (int p = 0; p < NUM_PAGES; p++) begin
      for (int d = 0; d < NUM_DIGITS; d++) begin
        if (page_q == PW'(p) && idx_q == DW'(d)) begin
          nibble = page_data[(p*NUM_DIGITS+d)*4 +: 4];
          dp_req = page_dp[p*NUM_DIGITS+d];
        end
      end
    end
    if (blank[idx_q]) glyph_d = '{seg: SEG_BLANK, dp: 1'b1};
    else              glyph_d = '{seg: hex2seg(nibble), dp: ~dp_req};

    page_d = page_q;
    if (btn_rise) page_d = (page_q == PW'(NUM_PAGES - 1)) ? '0 : page_q + 1'b1;

    // Anodes are registered from next-state values so the pins change on
    // exactly the cycle the counter does, with no decode glitches.
    an_d = '1;
    if (live_d && cnt_d >= SW'(GUARD_CYCLES) && cnt_d[SW-1 -: 4] < brightness)
      an_d[disp_d] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      disp_q  <= '0;
      live_q  <= 1'b0;
      page_q  <= '0;
      glyph_q <= '{seg: SEG_BLANK, dp: 1'b1};
      an_q    <= '1;
    end else begin
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      disp_q <= disp_d;
      live_q <= live_d;
      page_q <= page_d;
      an_q   <= an_d;
      // Glyph is captured once per slot, so page or data changes only show
      // up at a slot boundary.
      if (slot_end) glyph_q <= glyph_d;
    end
  end

  assign an       = an_q;
  assign seg      = glyph_q.seg;
  assign dp       = glyph_q.dp;
  assign page_sel = page_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
module tb_seg_scan_ctrl;

  localparam int ND  = 4;
  localparam int NP  = 3;
  localparam int SD  = 32;
  localparam int GC  = 1;
  localparam int DEB = 8;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [NP*ND*4-1:0] page_data;
  logic [NP*ND-1:0]  page_dp;
  logic [ND-1:0]     blank;
  logic [3:0]        brightness;
  logic              btn_next;
  logic [ND-1:0]     an;
  logic [6:0]        seg;
  logic              dp;
  logic [1:0]        page_sel;

  seg_scan_ctrl #(
    .NUM_DIGITS     (ND),
    .NUM_PAGES      (NP),
    .SCAN_DIV       (SD),
    .GUARD_CYCLES   (GC),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .page_data (page_data),
    .page_dp   (page_dp),
    .blank     (blank),
    .brightness(brightness),
    .btn_next  (btn_next),
    .an        (an),
    .seg       (seg),
    .dp        (dp),
    .page_sel  (page_sel)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ND-1:0] an;
    logic [6:0]    seg;
    logic          dp;
    logic [1:0]    page;
  } obs_t;

  obs_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_mon    = 0;
  int   n_m      = 0;   // model: rising edges since reset released
  int   page_m   = 0;   // model: selected page

  logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Reference model: from the slot number and position in the slot it decides
  // which digit is shown, whether it is lit, and which glyph was latched at the
  // slot start. The button is modelled as "DEB consecutive samples differing
  // from the accepted level", with the two synchroniser delays added on.
  initial begin
    int         slot, c, d;
    logic       lvl_m;
    int         run_m;
    int         incr_at[$];
    logic [6:0] seg_m;
    logic       dp_m;
    logic [3:0] nib;
    obs_t       e;
    lvl_m = 1'b0; run_m = 0; seg_m = 7'h7F; dp_m = 1'b1;
    forever begin
      @(posedge clk);
      if (!reset_n) begin
        n_m = 0; page_m = 0; lvl_m = 1'b0; run_m = 0;
        incr_at.delete();
        seg_m = 7'h7F; dp_m = 1'b1;
        e = '{an: '1, seg: 7'h7F, dp: 1'b1, page: 2'd0};
      end else begin
        n_m++;
        slot = n_m / SD;
        c    = n_m % SD;
        if (c == 0) begin
          d   = (slot - 1) % ND;
          nib = page_data[(page_m*ND+d)*4 +: 4];
          if (blank[d]) begin
            seg_m = 7'h7F; dp_m = 1'b1;
          end else begin
            seg_m = hex_tab[nib]; dp_m = !page_dp[page_m*ND+d];
          end
        end
        if (btn_next != lvl_m) begin
          run_m++;
          if (run_m == DEB) begin
            lvl_m = btn_next;
            run_m = 0;
            if (lvl_m) incr_at.push_back(n_m + 2);
          end
        end else begin
          run_m = 0;
        end
        while (incr_at.size() > 0 && incr_at[0] == n_m) begin
          void'(incr_at.pop_front());
          page_m = (page_m + 1) % NP;
        end
        e.an = '1;
        if (slot >= 1 && c >= GC && (c / (SD/16)) < int'(brightness))
          e.an[(slot - 1) % ND] = 1'b0;
        e.seg  = seg_m;
        e.dp   = dp_m;
        e.page = 2'(page_m);
      end
      sb_q.push_back(e);
    end
  end

  // Monitor: one observation per cycle, sampled away from the active edge.
  initial begin
    obs_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        n_mon++;
        check("an", 32'(an), 32'(e.an));
        check("seg", 32'(seg), 32'(e.seg));
        check("dp", 32'(dp), 32'(e.dp));
        check("page_sel", 32'(page_sel), 32'(e.page));
        check("one_anode_max", 32'($countones(~an) <= 1), 32'd1);
      end
    end
  end

  task automatic wait_cycles(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic press(input int len);
    btn_next = 1'b1;
    wait_cycles(len);
    btn_next = 1'b0;
    wait_cycles(24);
  endtask

  initial begin
    bit found;
    reset_n    = 1'b0;
    page_data  = {16'h9B07, 16'h3C5E, 16'h12AF};
    page_dp    = '0;
    blank      = '0;
    brightness = 4'd15;
    btn_next   = 1'b0;
    wait_cycles(3);
    check("reset_an", 32'(an), 32'hF);
    check("reset_seg", 32'(seg), 32'h7F);
    check("reset_dp", 32'(dp), 32'd1);
    check("reset_page", 32'(page_sel), 32'd0);
    reset_n = 1'b1;

    // Scan at full brightness, then brightness 0 and 8.
    wait_cycles(5*SD);
    brightness = 4'd0;  wait_cycles(2*SD);
    brightness = 4'd8;  wait_cycles(2*SD);
    brightness = 4'd15;

    // Blank digit 2, decimal point on page 0 digit 1.
    blank = 4'b0100; page_dp[1] = 1'b1;
    wait_cycles(5*SD);
    blank = '0; page_dp = '0;

    // Debounce: short pulse ignored, then three presses wrap 1, 2, 0.
    press(5);  check("pulse_ignored", 32'(page_sel), 32'd0);
    press(12); check("press_1", 32'(page_sel), 32'd1);
    press(12); check("press_2", 32'(page_sel), 32'd2);
    press(12); check("press_wrap", 32'(page_sel), 32'd0);
    wait_cycles(2*SD);

    // Randomised phase.
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 4))
        0: brightness = 4'($urandom_range(0, 15));
        1: blank = ND'($urandom);
        2: page_data = {16'($urandom), $urandom};
        3: page_dp = (NP*ND)'($urandom);
        default: begin
          btn_next = 1'b1;
          wait_cycles($urandom_range(1, 14));
          btn_next = 1'b0;
        end
      endcase
      wait_cycles($urandom_range(5, 80));
    end
    brightness = 4'd15; blank = '0;
    wait_cycles(24);

    // Reset in the middle of digit 2's slot on page 2.
    for (int i = 0; i < 3 && page_m != 2; i++) press(12);
    check("pre_reset_page", 32'(page_sel), 32'd2);
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      if (n_m >= SD && ((n_m/SD - 1) % ND) == 2 && (n_m % SD) == 10) found = 1'b1;
      else @(negedge clk);
    end
    check("reach_digit2", 32'(found), 32'd1);
    reset_n = 1'b0;
    wait_cycles(1);
    check("midreset_an", 32'(an), 32'hF);
    check("midreset_seg", 32'(seg), 32'h7F);
    check("midreset_page", 32'(page_sel), 32'd0);
    reset_n = 1'b1;
    wait_cycles(SD + 5);
    check("restart_digit0", 32'(an), 32'hE);
    wait_cycles(3*SD);

    check("monitor_active", 32'(n_mon > 1000), 32'd1);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
